btb_storage: RTL and testbench
==============================

Name: btb_storage

Overview:
- Register-file backing store for the 8-set, 2-way branch target buffer.
- Supplies the combinational read set and LRU vector to the IF-stage BTB read logic.
- Takes LRU touches from IF hits and branch-resolution updates from EX.
- On resolution it updates 2-bit predictor state, target, allocation and replacement through a one-entry staging register.

Parameters:
NUM_SETS, 8, number of sets; index width is log2(NUM_SETS) = 3
TAG_W, 27, tag width; tag = pc[31:5], index = pc[4:2]

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
read_index  input  3  IF PC[4:2], selects the set presented on read_set
read_set  output  128  {way1[63:0], way2[63:0]}; combinational from the array
LRU  output  8  LRU bit per set, registered
lru_touch  input  1  IF lookup hit this cycle (read valid and not stalled)
next_LRU_read  input  1  LRU value for read_index on an IF hit; 1 = way2 most recently used
update_valid  input  1  EX resolved a branch/jump this cycle
update_pc  input  32  PC of the resolved branch
update_taken  input  1  actual outcome
update_target  input  32  resolved target address
flush  input  1  invalidate all entries (e.g. fence.i / context switch)
busy  output  1  staging register occupied this cycle

Behaviour:
- Entry format, 64 bits: valid[63], tag[62:36], target[35:4], state[3:2], [1:0] = 0 always.
- State encoding: 00 strongNT, 01 weakNT, 10 strongT, 11 weakT; predicted taken = state[1].
- Reset (rst high at clk edge):
  - all 8 sets cleared to 0; LRU = 8'h00; staging register invalid; busy = 0.
  - read_set reads 0 for every index.
- Stage 1, capture: when update_valid = 1 at an edge, update_pc, update_taken and update_target latch into the staging register; busy = 1 the following cycle. Back-to-back updates are accepted every cycle and overwrite the staging register.
- Stage 2, commit: at the edge after capture, the staged update writes the array. Commit is 1 cycle after capture; the new data is visible on read_set 2 edges after update_valid (without the bypass feature).
- Commit rules: tag = pc[31:5], set s = pc[4:2]. A hit is a valid way with a matching tag; if both ways match, way1 takes priority.
  - Hit: state steps by the saturating walk below; target is overwritten with update_target; LRU[s] = 1 if the hit way is way2, else 0.
  - Taken walk: 00->01->11->10, 10 holds.
  - Not-taken walk: 10->11->01->00, 00 holds.
  - Miss with taken = 1: allocate {1, tag, target, 2'b11, 2'b00}.
    - Victim: invalid way1 first, then invalid way2, else way2 if LRU[s] = 0, way1 if LRU[s] = 1.
    - LRU[s] then marks the allocated way as most recently used.
  - Miss with taken = 0: no array write, no LRU change.
- LRU touch: lru_touch = 1 sets LRU[read_index] = next_LRU_read at the edge. If a commit targets the same set in the same cycle, the commit's LRU value wins.
- Flush:
  - flush = 1 clears every valid bit and the staging register at the edge.
  - An update_valid in the same cycle is dropped.
  - LRU is preserved.
- Priority: rst > flush > commit > lru_touch.
- Reset mid-operation: a pending staged update is discarded, never committed.

Optional Feature:
BTB_BYPASS_EN:
- Defined: when the staging register is valid, its set equals read_index and its commit would write the array, read_set presents the post-commit set in the same cycle. Update-to-read latency is 1 edge.
- Undefined: read_set reflects only the array contents; the combinational path from the staging register is absent.

Test Plan:
- Reset, then read_index 0..7 -> read_set = 0 on all indices; LRU = 8'h00; busy = 0.
- update_valid, pc = 32'h0000_0044, taken = 1, target = 32'h0000_0100 -> 2 edges later, index 1 read_set[127:64] = {1, 27'h2, 32'h100, 2'b11, 2'b00}; LRU[1] = 0.
- Four taken updates to the same pc 32'h44 -> state 11 -> 10 -> 10 -> 10; then two not-taken -> 11 -> 01; predicted-taken bit drops on the second.
- Fill set 1 with pc 32'h44 (way1) and 32'h64 (way2); lru_touch with next_LRU_read = 0 on index 1; taken update pc 32'h84 -> way2 replaced; way1 tag 27'h2 retained.
- Same-cycle commit to set 3 hitting way2 plus lru_touch on index 3 with next_LRU_read = 0 -> LRU[3] = 1.
- flush with valid entries and update_valid in the same cycle -> all valid bits 0 next cycle; update not committed; LRU unchanged. With BTB_BYPASS_EN, a read of the updated index one cycle after update_valid shows the new entry.

Source files
------------

// File: rtl/btb_storage.sv
// btb_storage: register-file backing store for the 8-set, 2-way branch target buffer.
//
// Each set holds two 64-bit entries:
//   valid[63] | tag[62:36] | target[35:4] | state[3:2] | 2'b00
//
// Branch resolutions from EX are first captured in a one-entry staging
// register. They are committed to the array (predictor walk, target refresh,
// allocation and replacement) on the following edge.
//
// Optional feature, enabled by defining the macro BTB_BYPASS_EN:
//   While the staging register holds an update that is about to write the set
//   currently being read, read_set shows the post-commit contents of that set.
//   This cuts the update-to-read latency from two edges to one.
module btb_storage #(
    parameter int  NUM_SETS = 8,
    parameter int  TAG_W    = 27,
    localparam int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    read_index,
    output logic [127:0]        read_set,
    output logic [NUM_SETS-1:0] LRU,
    input  logic                lru_touch,
    input  logic                next_LRU_read,
    input  logic                update_valid,
    input  logic [31:0]         update_pc,
    input  logic                update_taken,
    input  logic [31:0]         update_target,
    input  logic                flush,
    output logic                busy
);

    // Two-bit predictor encodings. Bit 1 is the predicted-taken bit.
    localparam logic [1:0] ST_STRONG_NT = 2'b00;
    localparam logic [1:0] ST_WEAK_NT   = 2'b01;
    localparam logic [1:0] ST_STRONG_T  = 2'b10;
    localparam logic [1:0] ST_WEAK_T    = 2'b11;

    // Storage array, one entry per way per set, plus the per-set LRU bits.
    // An LRU bit of 1 means way2 was used most recently.
    logic [63:0]         way1_q [NUM_SETS];
    logic [63:0]         way2_q [NUM_SETS];
    logic [NUM_SETS-1:0] lru_q;

    // Staging register that holds one resolved branch awaiting commit.
    logic                stg_valid_q;
    logic [31:2]         stg_pc_q;
    logic                stg_taken_q;
    logic [31:0]         stg_target_q;

    // Fields of the staged update, plus the current contents of its set.
    logic [IDX_W-1:0]    stg_set;
    logic [TAG_W-1:0]    stg_tag;
    logic [63:0]         cur_w1;
    logic [63:0]         cur_w2;
    logic                hit_w1;
    logic                hit_w2;

    // Result of the commit: post-commit set contents and the LRU update.
    logic [63:0]         new_w1;
    logic [63:0]         new_w2;
    logic                commit_write;
    logic                commit_lru_we;
    logic                commit_lru_val;
    logic [63:0]         alloc_entry;

    // The byte-offset bits of the PC play no part in tag or index.
    logic                unused_pc_bits;
    assign unused_pc_bits = ^update_pc[1:0];

    // Saturating walk:
    //   taken:     00 -> 01 -> 11 -> 10 (10 holds)
    //   not taken: 10 -> 11 -> 01 -> 00 (00 holds)
    function automatic logic [1:0] next_state(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            case (cur)
                ST_STRONG_NT: nxt = ST_WEAK_NT;
                ST_WEAK_NT:   nxt = ST_WEAK_T;
                ST_WEAK_T:    nxt = ST_STRONG_T;
                default:      nxt = ST_STRONG_T;
            endcase
        end else begin
            case (cur)
                ST_STRONG_T:  nxt = ST_WEAK_T;
                ST_WEAK_T:    nxt = ST_WEAK_NT;
                ST_WEAK_NT:   nxt = ST_STRONG_NT;
                default:      nxt = ST_STRONG_NT;
            endcase
        end
        return nxt;
    endfunction

    assign stg_set     = stg_pc_q[IDX_W+1:2];
    assign stg_tag     = stg_pc_q[31:IDX_W+2];
    assign cur_w1      = way1_q[stg_set];
    assign cur_w2      = way2_q[stg_set];
    assign hit_w1      = cur_w1[63] && (cur_w1[62:36] == stg_tag);
    assign hit_w2      = cur_w2[63] && (cur_w2[62:36] == stg_tag);
    assign alloc_entry = {1'b1, stg_tag, stg_target_q, ST_WEAK_T, 2'b00};

    // Work out what the staged update does to its set: hit update, allocation or nothing.
    always_comb begin
        new_w1         = cur_w1;
        new_w2         = cur_w2;
        commit_write   = 1'b0;
        commit_lru_we  = 1'b0;
        commit_lru_val = 1'b0;
        if (stg_valid_q) begin
            if (hit_w1) begin
                new_w1         = {cur_w1[63:36], stg_target_q,
                                  next_state(cur_w1[3:2], stg_taken_q), 2'b00};
                commit_write   = 1'b1;
                commit_lru_we  = 1'b1;
                commit_lru_val = 1'b0;
            end else if (hit_w2) begin
                new_w2         = {cur_w2[63:36], stg_target_q,
                                  next_state(cur_w2[3:2], stg_taken_q), 2'b00};
                commit_write   = 1'b1;
                commit_lru_we  = 1'b1;
                commit_lru_val = 1'b1;
            end else if (stg_taken_q) begin
                commit_write  = 1'b1;
                commit_lru_we = 1'b1;
                if (!cur_w1[63]) begin
                    new_w1         = alloc_entry;
                    commit_lru_val = 1'b0;
                end else if (!cur_w2[63]) begin
                    new_w2         = alloc_entry;
                    commit_lru_val = 1'b1;
                end else if (!lru_q[stg_set]) begin
                    new_w2         = alloc_entry;
                    commit_lru_val = 1'b1;
                end else begin
                    new_w1         = alloc_entry;
                    commit_lru_val = 1'b0;
                end
            end
        end
    end

    // Present the selected set to the IF stage, optionally forwarding a pending commit.
    always_comb begin
        read_set = {way1_q[read_index], way2_q[read_index]};
`ifdef BTB_BYPASS_EN
        if (commit_write && (stg_set == read_index)) begin
            read_set = {new_w1, new_w2};
        end
`endif
    end

    // Capture resolved branches; flush and reset throw away anything pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q  <= 1'b0;
            stg_pc_q     <= '0;
            stg_taken_q  <= 1'b0;
            stg_target_q <= '0;
        end else if (flush) begin
            stg_valid_q <= 1'b0;
        end else begin
            stg_valid_q <= update_valid;
            if (update_valid) begin
                stg_pc_q     <= update_pc[31:2];
                stg_taken_q  <= update_taken;
                stg_target_q <= update_target;
            end
        end
    end

    // Array contents: cleared on reset, invalidated on flush, otherwise written by the commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                way1_q[i] <= '0;
                way2_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                way1_q[i][63] <= 1'b0;
                way2_q[i][63] <= 1'b0;
            end
        end else if (commit_write) begin
            way1_q[stg_set] <= new_w1;
            way2_q[stg_set] <= new_w2;
        end
    end

    // LRU bits: IF touches apply first and a commit to the same set overrides them.
    always_ff @(posedge clk) begin
        if (rst) begin
            lru_q <= '0;
        end else if (!flush) begin
            if (lru_touch) begin
                lru_q[read_index] <= next_LRU_read;
            end
            if (commit_lru_we) begin
                lru_q[stg_set] <= commit_lru_val;
            end
        end
    end

    assign LRU  = lru_q;
    assign busy = stg_valid_q;

endmodule

// File: tb/tb_btb_storage.sv
// tb_btb_storage: checks btb_storage against a behavioural model of the BTB.
// The model keeps each way as {valid, tag, target, confidence level 0..3}.
// It also keeps a one-deep pending-update slot.
// Directed sequences pin the model with literal values, then random traffic follows.
// Build with +define+BTB_BYPASS_EN to check the forwarding variant.
module tb_btb_storage;

    typedef struct {
        bit        valid;
        bit [26:0] tag;
        bit [31:0] target;
        int        level;
    } way_t;

    typedef struct {
        bit        rst;
        bit        flush;
        bit        lru_touch;
        bit        next_lru;
        bit        update_valid;
        bit        update_taken;
        bit [2:0]  read_index;
        bit [31:0] update_pc;
        bit [31:0] update_target;
    } stim_t;

    logic         clk;
    logic         rst;
    logic [2:0]   read_index;
    logic [127:0] read_set;
    logic [7:0]   lru;
    logic         lru_touch;
    logic         next_lru_read;
    logic         update_valid;
    logic [31:0]  update_pc;
    logic         update_taken;
    logic [31:0]  update_target;
    logic         flush;
    logic         busy;

    int checks;
    int failures;
    bit model_known;

    way_t      mw [8][2];
    bit [7:0]  mlru;
    bit        p_valid;
    bit [31:0] p_pc;
    bit        p_taken;
    bit [31:0] p_target;

    btb_storage dut (
        .clk           (clk),
        .rst           (rst),
        .read_index    (read_index),
        .read_set      (read_set),
        .LRU           (lru),
        .lru_touch     (lru_touch),
        .next_LRU_read (next_lru_read),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_taken  (update_taken),
        .update_target (update_target),
        .flush         (flush),
        .busy          (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Confidence level 0 strongNT, 1 weakNT, 2 weakT, 3 strongT -> stored bits.
    function automatic bit [1:0] level_bits(int l);
        case (l)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic bit [63:0] enc(way_t w);
        return {w.valid, w.tag, w.target, level_bits(w.level), 2'b00};
    endfunction

    function automatic way_t hit_step(way_t w);
        way_t r;
        r = w;
        r.target = p_target;
        if (p_taken) r.level = (w.level < 3) ? w.level + 1 : 3;
        else         r.level = (w.level > 0) ? w.level - 1 : 0;
        return r;
    endfunction

    // Effect of the pending update on its set, without changing the model.
    function automatic void model_commit(output way_t n0, output way_t n1,
                                         output bit wrote, output bit lru_we,
                                         output bit lru_val);
        int        s;
        bit [26:0] tag;
        way_t      a;
        s       = int'(p_pc[4:2]);
        tag     = p_pc[31:5];
        n0      = mw[s][0];
        n1      = mw[s][1];
        wrote   = 0;
        lru_we  = 0;
        lru_val = 0;
        if (!p_valid) return;
        a.valid  = 1;
        a.tag    = tag;
        a.target = p_target;
        a.level  = 2;
        if (n0.valid && n0.tag == tag) begin
            n0 = hit_step(n0); wrote = 1; lru_we = 1; lru_val = 0;
        end else if (n1.valid && n1.tag == tag) begin
            n1 = hit_step(n1); wrote = 1; lru_we = 1; lru_val = 1;
        end else if (p_taken) begin
            wrote  = 1;
            lru_we = 1;
            if (!n0.valid)      begin n0 = a; lru_val = 0; end
            else if (!n1.valid) begin n1 = a; lru_val = 1; end
            else if (mlru[s])   begin n0 = a; lru_val = 0; end
            else                begin n1 = a; lru_val = 1; end
        end
    endfunction

    function automatic bit [127:0] model_read(bit [2:0] idx);
`ifdef BTB_BYPASS_EN
        way_t n0, n1;
        bit   wrote, we, v;
        if (p_valid && p_pc[4:2] == idx) begin
            model_commit(n0, n1, wrote, we, v);
            if (wrote) return {enc(n0), enc(n1)};
        end
`endif
        return {enc(mw[idx][0]), enc(mw[idx][1])};
    endfunction

    function automatic void model_step(stim_t s);
        way_t n0, n1;
        bit   wrote, we, v;
        if (s.rst) begin
            for (int i = 0; i < 8; i++) begin
                mw[i][0] = '{default: 0};
                mw[i][1] = '{default: 0};
            end
            mlru    = 8'h00;
            p_valid = 0;
        end else if (s.flush) begin
            for (int i = 0; i < 8; i++) begin
                mw[i][0].valid = 0;
                mw[i][1].valid = 0;
            end
            p_valid = 0;
        end else begin
            model_commit(n0, n1, wrote, we, v);
            if (s.lru_touch) mlru[s.read_index] = s.next_lru;
            if (wrote) begin
                mw[p_pc[4:2]][0] = n0;
                mw[p_pc[4:2]][1] = n1;
            end
            if (we) mlru[p_pc[4:2]] = v;
            p_valid = s.update_valid;
            if (s.update_valid) begin
                p_pc     = s.update_pc;
                p_taken  = s.update_taken;
                p_target = s.update_target;
            end
        end
    endfunction

    task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        if (!model_known) return;
        checkOutput("model read_set", read_set, model_read(read_index));
        checkOutput("model LRU", {120'd0, lru}, {120'd0, mlru});
        checkOutput("model busy", {127'd0, busy}, {127'd0, p_valid});
    endtask

    // Drive one cycle of inputs, compare outputs, then advance the model past the edge.
    task automatic applyStimulus(stim_t s);
        rst           = s.rst;
        flush         = s.flush;
        lru_touch     = s.lru_touch;
        next_lru_read = s.next_lru;
        update_valid  = s.update_valid;
        update_taken  = s.update_taken;
        read_index    = s.read_index;
        update_pc     = s.update_pc;
        update_target = s.update_target;
        #1;
        compareModel();
        @(posedge clk);
        model_step(s);
        if (s.rst) model_known = 1;
        @(negedge clk);
    endtask

    function automatic stim_t idle(bit [2:0] idx);
        stim_t s;
        s            = '{default: 0};
        s.read_index = idx;
        return s;
    endfunction

    function automatic stim_t upd(bit [31:0] pc, bit taken, bit [31:0] target, bit [2:0] idx);
        stim_t s;
        s               = idle(idx);
        s.update_valid  = 1;
        s.update_pc     = pc;
        s.update_taken  = taken;
        s.update_target = target;
        return s;
    endfunction

    function automatic stim_t do_reset();
        stim_t s;
        s     = idle(3'd0);
        s.rst = 1;
        return s;
    endfunction

    initial begin
        stim_t     s;
        bit [1:0]  exp_state [6];
        bit        taken_seq [6];
        bit [63:0] exp_entry;

        exp_state = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
        taken_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        checks      = 0;
        failures    = 0;
        model_known = 0;
        clk           = 0;
        rst           = 1;
        flush         = 0;
        lru_touch     = 0;
        next_lru_read = 0;
        update_valid  = 0;
        update_taken  = 0;
        read_index    = 0;
        update_pc     = 0;
        update_target = 0;
        @(negedge clk);

        // Reset clears the entire array, LRU and the staging register.
        applyStimulus(do_reset());
        applyStimulus(do_reset());
        for (int i = 0; i < 8; i++) begin
            applyStimulus(idle(3'(i)));
            checkOutput("reset read_set", read_set, 128'd0);
        end
        checkOutput("reset LRU", {120'd0, lru}, 128'd0);
        checkOutput("reset busy", {127'd0, busy}, 128'd0);

        // Allocation of a taken miss into way1 of set 1.
        exp_entry = {1'b1, 27'h2, 32'h0000_0100, 2'b11, 2'b00};
        applyStimulus(upd(32'h0000_0044, 1'b1, 32'h0000_0100, 3'd1));
        checkOutput("busy after capture", {127'd0, busy}, {127'd0, 1'b1});
`ifdef BTB_BYPASS_EN
        checkOutput("bypass way1", {64'd0, read_set[127:64]}, {64'd0, exp_entry});
`else
        checkOutput("no early read", read_set, 128'd0);
`endif
        applyStimulus(idle(3'd1));
        checkOutput("alloc way1", {64'd0, read_set[127:64]}, {64'd0, exp_entry});
        checkOutput("alloc LRU1", {127'd0, lru[1]}, 128'd0);
        checkOutput("busy drained", {127'd0, busy}, 128'd0);

        // Predictor walk: four taken then two not-taken resolutions.
        applyStimulus(do_reset());
        for (int k = 0; k < 6; k++) begin
            applyStimulus(upd(32'h0000_0044, taken_seq[k], 32'h0000_0100 + 32'(k), 3'd1));
            applyStimulus(idle(3'd1));
            checkOutput("walk state", {126'd0, read_set[67:66]}, {126'd0, exp_state[k]});
            checkOutput("walk target", {96'd0, read_set[99:68]}, {96'd0, 32'h0000_0100 + 32'(k)});
        end

        // Replacement honours the IF-updated LRU bit.
        applyStimulus(do_reset());
        applyStimulus(upd(32'h0000_0044, 1'b1, 32'h0000_0200, 3'd1));
        applyStimulus(idle(3'd1));
        applyStimulus(upd(32'h0000_0064, 1'b1, 32'h0000_0300, 3'd1));
        applyStimulus(idle(3'd1));
        checkOutput("fill LRU1", {127'd0, lru[1]}, {127'd0, 1'b1});
        s = idle(3'd1);
        s.lru_touch = 1;
        s.next_lru  = 0;
        applyStimulus(s);
        checkOutput("touch LRU1", {127'd0, lru[1]}, 128'd0);
        applyStimulus(upd(32'h0000_0084, 1'b1, 32'h0000_0400, 3'd1));
        applyStimulus(idle(3'd1));
        checkOutput("victim way2 tag", {101'd0, read_set[62:36]}, {101'd0, 27'h4});
        checkOutput("kept way1 tag", {101'd0, read_set[126:100]}, {101'd0, 27'h2});
        checkOutput("replace LRU1", {127'd0, lru[1]}, {127'd0, 1'b1});

        // A commit and an IF touch on the same set: the commit wins.
        applyStimulus(do_reset());
        applyStimulus(upd(32'h0000_002C, 1'b1, 32'h0000_0500, 3'd3));
        applyStimulus(idle(3'd3));
        applyStimulus(upd(32'h0000_004C, 1'b1, 32'h0000_0504, 3'd3));
        applyStimulus(idle(3'd3));
        s = upd(32'h0000_004C, 1'b1, 32'h0000_0508, 3'd3);
        s.lru_touch = 1;
        s.next_lru  = 0;
        applyStimulus(s);
        checkOutput("touch LRU3", {127'd0, lru[3]}, 128'd0);
        s = idle(3'd3);
        s.lru_touch = 1;
        s.next_lru  = 0;
        applyStimulus(s);
        checkOutput("commit beats touch", {127'd0, lru[3]}, {127'd0, 1'b1});
        checkOutput("way2 hit state", {126'd0, read_set[3:2]}, {126'd0, 2'b10});

        // Flush drops a same-cycle update, invalidates everything and keeps LRU.
        s = upd(32'h0000_0010, 1'b1, 32'h0000_0600, 3'd4);
        s.flush = 1;
        applyStimulus(s);
        checkOutput("flush busy", {127'd0, busy}, 128'd0);
        checkOutput("flush LRU", {120'd0, lru}, {120'd0, 8'h08});
        applyStimulus(idle(3'd4));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(idle(3'(i)));
            checkOutput("flush valid bits", {126'd0, read_set[127], read_set[63]}, 128'd0);
        end
        checkOutput("flush LRU kept", {120'd0, lru}, {120'd0, 8'h08});

        // Random traffic on a small tag pool so hits, evictions and bypasses all occur.
        applyStimulus(do_reset());
        for (int n = 0; n < 4000; n++) begin
            s.rst           = ($urandom_range(0, 199) == 0);
            s.flush         = ($urandom_range(0, 49) == 0);
            s.lru_touch     = ($urandom_range(0, 9) < 4);
            s.next_lru      = 1'($urandom_range(0, 1));
            s.update_valid  = ($urandom_range(0, 9) < 6);
            s.update_taken  = ($urandom_range(0, 3) != 0);
            s.read_index    = 3'($urandom_range(0, 7));
            s.update_pc     = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2)
                              | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) s.update_pc = $urandom;
            s.update_target = $urandom;
            applyStimulus(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
